// File: rtl/comm_ctrl.sv
// Source sequencer: routes fibonacci or timer words to the buffer write port,
// absorbs one word in a skid register when the buffer stalls, and drains on stop.
module comm_ctrl #(
   parameter int DATA_W        = 16,
   parameter int CNT_W         = 16,
   parameter int DRAIN_TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_f,
   input  logic              start_t,
   input  logic              stop_f_t,
   input  logic              f_valid,
   input  logic [DATA_W-1:0] f_out,
   input  logic              t_valid,
   input  logic [DATA_W-1:0] t_out,
   input  logic              buffer_full,
   input  logic              buffer_empty,
   input  logic              data_2_valid,
   output logic              f_en,
   output logic              t_en,
   output logic              data_1_en,
   output logic [DATA_W-1:0] data_1,
   output logic              parity,
   output logic [5:0]        state_led,
   output logic [CNT_W-1:0]  word_cnt,
   output logic              drain_err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_COMM_F = 3'd1,
      S_COMM_T = 3'd2,
      S_DRAIN  = 3'd3,
      S_WAIT_F = 3'd4,
      S_WAIT_T = 3'd5
   } state_t;

   localparam int              DC_W    = $clog2(DRAIN_TIMEOUT) + 1;
   localparam logic [DC_W-1:0] DC_LAST = DC_W'(DRAIN_TIMEOUT - 1);

   state_t            state, state_nxt;
   logic              start_f_d, start_t_d, stop_d;
   logic              f_edge, t_edge, stop_edge;
   logic              src_valid;
   logic [DATA_W-1:0] src_out;
   logic              skid_v, skid_v_nxt, skid_ld;
   logic [DATA_W-1:0] skid_data;
   logic              vld_p0;
   logic [DATA_W-1:0] data_p0;
   logic              vld_p1;
   logic [DATA_W-1:0] data_p1;
   logic              par_p1;
   logic [DC_W-1:0]   drain_cnt;
   logic              drain_to;
   logic [CNT_W-1:0]  cnt;
   logic              err;

   function automatic logic parity_of(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction

   assign f_edge    = start_f  & ~start_f_d;
   assign t_edge    = start_t  & ~start_t_d;
   assign stop_edge = stop_f_t & ~stop_d;

   assign src_valid = (state == S_COMM_F) ? f_valid : t_valid;
   assign src_out   = (state == S_COMM_F) ? f_out   : t_out;

   always_comb begin
      state_nxt  = state;
      skid_v_nxt = skid_v;
      skid_ld    = 1'b0;
      vld_p0     = 1'b0;
      data_p0    = src_out;
      drain_to   = 1'b0;
      case (state)
         S_IDLE: begin
            if (f_edge)      state_nxt = S_COMM_F;
            else if (t_edge) state_nxt = S_COMM_T;
         end
         S_COMM_F, S_COMM_T: begin
            if (src_valid && !buffer_full) begin
               vld_p0 = 1'b1;
            end else if (src_valid) begin
               skid_ld    = 1'b1;
               skid_v_nxt = 1'b1;
            end
            if (stop_edge)        state_nxt = S_DRAIN;
            else if (buffer_full) state_nxt = (state == S_COMM_F) ? S_WAIT_F : S_WAIT_T;
         end
         S_WAIT_F, S_WAIT_T: begin
            if (stop_edge) begin
               state_nxt  = S_DRAIN;
               skid_v_nxt = 1'b0;
            end else if (!buffer_full) begin
               state_nxt = (state == S_WAIT_F) ? S_COMM_F : S_COMM_T;
               if (skid_v) begin
                  vld_p0     = 1'b1;
                  data_p0    = skid_data;
                  skid_v_nxt = 1'b0;
               end
            end
         end
         S_DRAIN: begin
            skid_v_nxt = 1'b0;
            if (buffer_empty && !data_2_valid) begin
               state_nxt = S_IDLE;
            end else if (drain_cnt == DC_LAST) begin
               state_nxt = S_IDLE;
               drain_to  = 1'b1;
            end
         end
         default: begin
            state_nxt  = S_IDLE;
            skid_v_nxt = 1'b0;
         end
      endcase
   end

   // p0 -> p1: registered write port, counters and sticky status
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         start_f_d <= 1'b0;
         start_t_d <= 1'b0;
         stop_d    <= 1'b0;
         skid_v    <= 1'b0;
         vld_p1    <= 1'b0;
         data_p1   <= '0;
         par_p1    <= 1'b0;
         cnt       <= '0;
         drain_cnt <= '0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         start_f_d <= start_f;
         start_t_d <= start_t;
         stop_d    <= stop_f_t;
         skid_v    <= skid_v_nxt;
         vld_p1    <= vld_p0;
         if (vld_p0) begin
            data_p1 <= data_p0;
            par_p1  <= parity_of(data_p0);
         end
         if (vld_p1) cnt <= cnt + CNT_W'(1);
         drain_cnt <= (state == S_DRAIN) ? drain_cnt + DC_W'(1) : '0;
         if (drain_to) err <= 1'b1;
      end
   end

   // Skid word is qualified by skid_v, so its storage needs no reset.
   always_ff @(posedge clk) begin
      if (skid_ld) skid_data <= src_out;
   end

   assign f_en      = (state == S_COMM_F);
   assign t_en      = (state == S_COMM_T);
   assign data_1_en = vld_p1;
   assign data_1    = data_p1;
   assign parity    = par_p1;
   assign state_led = 6'b000001 << state;
   assign word_cnt  = cnt;
   assign drain_err = err;

endmodule

// File: tb/tb_comm_ctrl.sv
// Directed bench for comm_ctrl: per-cycle vector table plus drain timeout and async reset sequences.
module tb_comm_ctrl;

   localparam logic [5:0] L_I  = 6'h01;
   localparam logic [5:0] L_CF = 6'h02;
   localparam logic [5:0] L_CT = 6'h04;
   localparam logic [5:0] L_DR = 6'h08;
   localparam logic [5:0] L_WF = 6'h10;
   localparam logic [5:0] L_WT = 6'h20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_f, start_t, stop_f_t, f_valid, t_valid;
   logic [15:0] f_out, t_out;
   logic        buffer_full, buffer_empty, data_2_valid;
   logic        f_en, t_en, data_1_en, parity, drain_err;
   logic [15:0] data_1, word_cnt;
   logic [5:0]  state_led;

   always #5 clk = ~clk;

   comm_ctrl #(.DATA_W(16), .CNT_W(16), .DRAIN_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .start_f(start_f), .start_t(start_t), .stop_f_t(stop_f_t),
      .f_valid(f_valid), .f_out(f_out), .t_valid(t_valid), .t_out(t_out),
      .buffer_full(buffer_full), .buffer_empty(buffer_empty), .data_2_valid(data_2_valid),
      .f_en(f_en), .t_en(t_en), .data_1_en(data_1_en), .data_1(data_1),
      .parity(parity), .state_led(state_led), .word_cnt(word_cnt), .drain_err(drain_err)
   );

   typedef struct packed {
      logic sf, st, sp, fv;
      logic [15:0] fo;
      logic tv;
      logic [15:0] to;
      logic full, emp, d2v;
      logic fen, ten, den;
      logic [15:0] d1;
      logic [5:0] led;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic add(input logic sf, st, sp, fv, input logic [15:0] fo,
                      input logic tv, input logic [15:0] to, input logic full, emp, d2v,
                      input logic fen, ten, den, input logic [15:0] d1,
                      input logic [5:0] led, input logic [15:0] cnt);
      vec_t v;
      v = '{sf, st, sp, fv, fo, tv, to, full, emp, d2v, fen, ten, den, d1, led, cnt};
      vecs.push_back(v);
   endtask

   task automatic idle_inputs();
      start_f = 0; start_t = 0; stop_f_t = 0; f_valid = 0; t_valid = 0;
      f_out = '0; t_out = '0; buffer_full = 0; buffer_empty = 1; data_2_valid = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      // sf st sp fv fo        tv to        full emp d2v  fen ten den d1        led   cnt
      add(1, 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 0,     1, 0, 0, 16'h0,    L_CF, 0);
      add(0, 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 0,     1, 0, 0, 16'h0,    L_CF, 0);
      add(0, 0, 0, 1, 16'h1,    0, 16'h0,    0, 1, 0,     1, 0, 1, 16'h1,    L_CF, 0);
      add(0, 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 0,     1, 0, 0, 16'h1,    L_CF, 1);
      add(0, 0, 0, 1, 16'h1,    0, 16'h0,    0, 1, 0,     1, 0, 1, 16'h1,    L_CF, 1);
      add(0, 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 0,     1, 0, 0, 16'h1,    L_CF, 2);
      add(0, 0, 0, 1, 16'h2,    0, 16'h0,    0, 1, 0,     1, 0, 1, 16'h2,    L_CF, 2);
      add(0, 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 0,     1, 0, 0, 16'h2,    L_CF, 3);
      add(0, 0, 0, 1, 16'h3,    0, 16'h0,    0, 1, 0,     1, 0, 1, 16'h3,    L_CF, 3);
      add(0, 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 0,     1, 0, 0, 16'h3,    L_CF, 4);
      add(0, 0, 1, 0, 16'h0,    0, 16'h0,    0, 1, 0,     0, 0, 0, 16'h3,    L_DR, 4);
      add(0, 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 0,     0, 0, 0, 16'h3,    L_I,  4);
      // timer stall into the skid, then release
      add(0, 1, 0, 0, 16'h0,    0, 16'h0,    0, 1, 0,     0, 1, 0, 16'h3,    L_CT, 4);
      add(0, 0, 0, 0, 16'h0,    1, 16'h0042, 1, 1, 0,     0, 0, 0, 16'h3,    L_WT, 4);
      add(0, 0, 0, 0, 16'h0,    0, 16'h0,    1, 1, 0,     0, 0, 0, 16'h3,    L_WT, 4);
      add(0, 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 0,     0, 1, 1, 16'h0042, L_CT, 4);
      add(0, 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 0,     0, 1, 0, 16'h0042, L_CT, 5);
      add(0, 0, 1, 0, 16'h0,    0, 16'h0,    0, 1, 0,     0, 0, 0, 16'h0042, L_DR, 5);
      add(0, 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 0,     0, 0, 0, 16'h0042, L_I,  5);
      // simultaneous starts, then a start_t edge ignored outside idle
      add(1, 1, 0, 0, 16'h0,    0, 16'h0,    0, 1, 0,     1, 0, 0, 16'h0042, L_CF, 5);
      add(0, 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 0,     1, 0, 0, 16'h0042, L_CF, 5);
      add(0, 1, 0, 0, 16'h0,    0, 16'h0,    0, 1, 0,     1, 0, 0, 16'h0042, L_CF, 5);
      // stop beats full; drain waits for empty and read side idle
      add(0, 0, 1, 0, 16'h0,    0, 16'h0,    1, 0, 0,     0, 0, 0, 16'h0042, L_DR, 5);
      add(0, 0, 0, 0, 16'h0,    0, 16'h0,    0, 0, 0,     0, 0, 0, 16'h0042, L_DR, 5);
      add(0, 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 1,     0, 0, 0, 16'h0042, L_DR, 5);
      add(0, 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 0,     0, 0, 0, 16'h0042, L_I,  5);
      // stop while waiting discards the skid word
      add(1, 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 0,     1, 0, 0, 16'h0042, L_CF, 5);
      add(0, 0, 0, 1, 16'h00AA, 0, 16'h0,    1, 1, 0,     0, 0, 0, 16'h0042, L_WF, 5);
      add(0, 0, 1, 0, 16'h0,    0, 16'h0,    1, 1, 0,     0, 0, 0, 16'h0042, L_DR, 5);
      add(0, 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 0,     0, 0, 0, 16'h0042, L_I,  5);

      idle_inputs();
      #1 rst = 1'b0;
      #1;
      chk("reset_outputs",
          {f_en, t_en, data_1_en, data_1, parity, state_led, word_cnt, drain_err},
          {1'b0, 1'b0, 1'b0, 16'h0, 1'b0, L_I, 16'h0, 1'b0});
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         start_f = vecs[i].sf; start_t = vecs[i].st; stop_f_t = vecs[i].sp;
         f_valid = vecs[i].fv; f_out = vecs[i].fo; t_valid = vecs[i].tv; t_out = vecs[i].to;
         buffer_full = vecs[i].full; buffer_empty = vecs[i].emp; data_2_valid = vecs[i].d2v;
         step();
         chk($sformatf("vec%0d", i),
             {f_en, t_en, data_1_en, data_1, parity, state_led, word_cnt},
             {vecs[i].fen, vecs[i].ten, vecs[i].den, vecs[i].d1, ^vecs[i].d1, vecs[i].led, vecs[i].cnt});
      end
      chk("drain_err_clear", drain_err, 1'b0);

      // drain timeout with the buffer never emptying
      idle_inputs();
      start_f = 1; step();
      chk("t5_comm", state_led, L_CF);
      start_f = 0; stop_f_t = 1; buffer_empty = 0; step();
      stop_f_t = 0;
      n = 0;
      while (state_led == L_DR && n < 20) begin
         n++;
         step();
      end
      chk("t5_drain_cycles", n, 8);
      chk("t5_idle", state_led, L_I);
      chk("t5_err", drain_err, 1'b1);
      buffer_empty = 1; start_t = 1; step();
      start_t = 0; step();
      chk("t5_err_sticky", {drain_err, state_led}, {1'b1, L_CT});
      stop_f_t = 1; step();
      stop_f_t = 0; step();
      chk("t5_back_idle", state_led, L_I);

      // async reset in the middle of a write
      start_f = 1; step();
      start_f = 0; f_valid = 1; f_out = 16'h1234; step();
      f_valid = 0;
      chk("t6_write", {f_en, data_1_en, data_1, parity}, {1'b1, 1'b1, 16'h1234, ^(16'h1234)});
      #2 rst = 1'b0;
      #1;
      chk("t6_async",
          {f_en, t_en, data_1_en, data_1, parity, state_led, word_cnt, drain_err},
          {1'b0, 1'b0, 1'b0, 16'h0, 1'b0, L_I, 16'h0, 1'b0});
      step();
      rst = 1'b1;
      step();
      chk("t6_after", {f_en, data_1_en, state_led, word_cnt}, {1'b0, 1'b0, L_I, 16'h0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
